// File: rtl/plab5_mcore_mem_responder_sep.sv
// Single-outstanding memory responder for the separated mcore memory networks: full-line
// read/write on a local array after p_latency cycles. Optional macro PLAB5_MCORE_MEM_DOMAIN_CHECK_EN.
module plab5_mcore_mem_responder_sep #(
    parameter int p_mem_nbytes  = 256,
    parameter int p_latency     = 0,
    parameter int p_secure_base = 128,
    parameter int o             = 8,
    parameter int a             = 32,
    parameter int l             = 128
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [o+a+6:0]     memreq_control,
    input  logic [l-1:0]       memreq_data,
    input  logic               memreq_val,
    output logic               memreq_rdy,
    input  logic               memreq_domain,
    output logic [o+6:0]       memresp_control,
    output logic [l-1:0]       memresp_data,
    output logic               memresp_val,
    input  logic               memresp_rdy,
    output logic               memresp_domain
);
    localparam int NLINES = p_mem_nbytes / 16;
    localparam int IW = (NLINES > 1) ? $clog2(NLINES) : 1;
    localparam logic [3:0] LAT_INIT = (p_latency > 0) ? 4'(p_latency - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_next;
    logic [3:0]    cnt;
    logic [l-1:0]  mem [NLINES];

    logic [2:0]    req_type;
    logic [o-1:0]  req_opaque;
    logic [a-1:0]  req_addr;
    logic [3:0]    req_len;
    assign {req_type, req_opaque, req_addr, req_len} = memreq_control;

    // Only the line index of the address and none of len take part in the access.
    logic unused_req;
    assign unused_req = ^{req_len, req_addr};

    logic [2:0]    buf_type;
    logic [o-1:0]  buf_opaque;
    logic [IW-1:0] buf_idx;
    logic [l-1:0]  buf_data;
    logic          buf_domain;

    logic          accept, enter_resp;
    logic [2:0]    cur_type;
    logic [o-1:0]  cur_opaque;
    logic [IW-1:0] cur_idx;
    logic [l-1:0]  cur_data;
    logic          cur_domain, cur_denied, cur_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        memreq_rdy  = 1'b0;
        memresp_val = 1'b0;
        accept      = 1'b0;
        enter_resp  = 1'b0;
        case (state)
            IDLE: begin
                memreq_rdy = !reset;
                accept     = memreq_val && !reset;
                if (accept) begin
                    if (p_latency > 0) state_next = WAIT;
                    else begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                memresp_val = 1'b1;
                if (memresp_rdy) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          cnt <= 4'd0;
        else if (accept)                    cnt <= LAT_INIT;
        else if (state == WAIT && cnt != 0) cnt <= cnt - 4'd1;
    end

    // One-entry request buffer; holds the transaction across WAIT and RESP.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_type   <= req_type;
            buf_opaque <= req_opaque;
            buf_idx    <= req_addr[4 +: IW];
            buf_data   <= memreq_data;
            buf_domain <= memreq_domain;
        end
    end

    // With zero latency the access happens on the accept edge, so take fields straight from the request.
    always_comb begin
        if (state == IDLE) begin
            cur_type   = req_type;
            cur_opaque = req_opaque;
            cur_idx    = req_addr[4 +: IW];
            cur_data   = memreq_data;
            cur_domain = memreq_domain;
        end else begin
            cur_type   = buf_type;
            cur_opaque = buf_opaque;
            cur_idx    = buf_idx;
            cur_data   = buf_data;
            cur_domain = buf_domain;
        end
    end

`ifdef PLAB5_MCORE_MEM_DOMAIN_CHECK_EN
    assign cur_denied = !cur_domain &&
                        ({{(28 - IW){1'b0}}, cur_idx, 4'b0000} >= 32'(p_secure_base));
`else
    assign cur_denied = 1'b0;
`endif
    assign cur_write = (cur_type == 3'd1 || cur_type == 3'd2) && !cur_denied;

    always_ff @(posedge clk) begin
        if (enter_resp && cur_write) mem[cur_idx] <= cur_data;
    end

    // Response registers: loaded on the edge entering RESP, held through backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memresp_control <= '0;
            memresp_data    <= '0;
            memresp_domain  <= 1'b0;
        end else if (enter_resp) begin
            memresp_control <= {cur_type, cur_opaque, 4'd0};
            memresp_data    <= (cur_type == 3'd0 && !cur_denied) ? mem[cur_idx] : '0;
            memresp_domain  <= cur_domain;
        end
    end
endmodule
